dither_expand: RTL



---
 rtl/dither_expand_if.sv | 22 ++
 rtl/dither_expand.sv | 91 +++++++++
 2 files changed

// File: rtl/dither_expand_if.sv
// Stream bundle for dither_expand: rounded words in, reconstructed words out.
// The master side feeds din and consumes dout; the slave side is the block.
interface dither_expand_if #(
  parameter int DIN = 16
);
  logic           din_valid;
  logic           din_ready;
  logic [DIN-1:0] din_data;
  logic           dout_valid;
  logic           dout_ready;
  logic [DIN-1:0] dout_data;

  modport master (
    output din_valid, din_data, dout_ready,
    input  din_ready, dout_valid, dout_data
  );

  modport slave (
    input  din_valid, din_data, dout_ready,
    output din_ready, dout_valid, dout_data
  );
endinterface

// File: rtl/dither_expand.sv
// Refills rounded-away LSBs with LFSR dither, spreading each word over its cell.
// Output is a main register plus one skid register for full throughput.
module dither_expand #(
  parameter int          NBITS = 4,
  parameter int          DIN   = 16,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input logic            clk,
  input logic            rst,
  dither_expand_if.slave io
);

  localparam logic [DIN-1:0] HALF = DIN'(1) << (NBITS - 1);
  localparam logic [15:0]    MASK = 16'hB400;

  logic [15:0]    lfsr_q, lfsr_d;
  logic           out_valid_q, out_valid_d;
  logic [DIN-1:0] out_data_q, out_data_d;
  logic           skid_valid_q, skid_valid_d;
  logic [DIN-1:0] skid_data_q, skid_data_d;

  logic           din_ready;
  logic           accept;
  logic           pop;
  logic [DIN-1:0] word;
  logic [15:0]    lfsr_step;
  logic           unused_lsbs;

  // Ready depends only on local state and reset, never on dout_ready.
  assign din_ready   = ~skid_valid_q & ~rst;
  assign unused_lsbs = ^io.din_data[NBITS-1:0];

  assign io.din_ready  = din_ready;
  assign io.dout_valid = out_valid_q;
  assign io.dout_data  = out_data_q;

  always_comb begin
    lfsr_d       = lfsr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    accept = io.din_valid & din_ready;
    pop    = out_valid_q & io.dout_ready;

    word = {io.din_data[DIN-1:NBITS], lfsr_q[NBITS-1:0]} - HALF;
    lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ MASK)
                          : (lfsr_q >> 1);

    if (accept) begin
      lfsr_d = lfsr_step;
    end

    if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_data_d = word;
        end
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_data_d = word;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q       <= SEED;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      lfsr_q       <= lfsr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule
